// File: rtl/logic_axi4_stream_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-atomic AXI4-Stream arbiter.
package logic_axi4_stream_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int grantWidth(input int count);
    return (count >= 2) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// AXI4-Stream bundle carrying N parallel channels with flattened payload vectors.
interface logic_axi4_stream_packet_arbiter_if #(
  parameter int N           = 1,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);

  logic [N-1:0]               tvalid;
  logic [N-1:0]               tready;
  logic [N-1:0]               tlast;
  logic [N*TDATA_BYTES*8-1:0] tdata;
  logic [N*TDATA_BYTES-1:0]   tstrb;
  logic [N*TDATA_BYTES-1:0]   tkeep;
  logic [N*TDEST_WIDTH-1:0]   tdest;
  logic [N*TUSER_WIDTH-1:0]   tuser;
  logic [N*TID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tlast, tdata, tstrb, tkeep, tdest, tuser, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tstrb, tkeep, tdest, tuser, tid,
    output tready
  );

endinterface

// File: rtl/logic_axi4_stream_packet_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above the pointer, else wrap to the lowest.
module logic_axi4_stream_packet_arbiter_rr #(
  parameter int RX_COUNT    = 2,
  parameter int GRANT_WIDTH = 1
) (
  input  logic [RX_COUNT-1:0]    i_req,
  input  logic [GRANT_WIDTH-1:0] i_ptr,
  output logic [GRANT_WIDTH-1:0] o_winner,
  output logic                   o_any
);

  // Two passes: the upper pass covers [ptr, RX_COUNT-1], the second pass supplies the wrap.
  always_comb begin
    logic w_found;
    w_found  = 1'b0;
    o_winner = '0;
    for (int i = 0; i < RX_COUNT; i++) begin
      if (!w_found && i_req[i] && (GRANT_WIDTH'(i) >= i_ptr)) begin
        w_found  = 1'b1;
        o_winner = GRANT_WIDTH'(i);
      end
    end
    for (int i = 0; i < RX_COUNT; i++) begin
      if (!w_found && i_req[i]) begin
        w_found  = 1'b1;
        o_winner = GRANT_WIDTH'(i);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-atomic round-robin merge of RX_COUNT AXI4-Stream sources into one registered output stream.
module logic_axi4_stream_packet_arbiter
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter int RX_COUNT    = 2,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int GRANT_WIDTH = grantWidth(RX_COUNT)
) (
  input  logic                                  aclk,
  input  logic                                  areset_n,
  logic_axi4_stream_packet_arbiter_if.slave     rx,
  logic_axi4_stream_packet_arbiter_if.master    tx,
  output logic                                  grant_valid,
  output logic [GRANT_WIDTH-1:0]                grant
);

  localparam int DATA_W = TDATA_BYTES * 8;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [GRANT_WIDTH-1:0]   r_ptr;
  logic [GRANT_WIDTH-1:0]   r_grant;
  logic                     r_grantValid;
  logic [GRANT_WIDTH-1:0]   w_winner;
  logic [GRANT_WIDTH-1:0]   w_ptrNext;
  logic                     w_any;
  logic                     w_outReady;
  logic                     w_xfer;
  logic                     w_beatLast;
  logic [RX_COUNT-1:0]      w_rxReady;

  logic                     w_selValid;
  logic                     w_selLast;
  logic [DATA_W-1:0]        w_selData;
  logic [TDATA_BYTES-1:0]   w_selStrb;
  logic [TDATA_BYTES-1:0]   w_selKeep;
  logic [TDEST_WIDTH-1:0]   w_selDest;
  logic [TUSER_WIDTH-1:0]   w_selUser;
  logic [TID_WIDTH-1:0]     w_selId;

  logic                     r_txValid;
  logic                     r_txLast;
  logic [DATA_W-1:0]        r_txData;
  logic [TDATA_BYTES-1:0]   r_txStrb;
  logic [TDATA_BYTES-1:0]   r_txKeep;
  logic [TDEST_WIDTH-1:0]   r_txDest;
  logic [TUSER_WIDTH-1:0]   r_txUser;
  logic [TID_WIDTH-1:0]     r_txId;

  logic_axi4_stream_packet_arbiter_rr #(
    .RX_COUNT    (RX_COUNT),
    .GRANT_WIDTH (GRANT_WIDTH)
  ) u_rr (
    .i_req    (rx.tvalid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_selValid = 1'b0;
    w_selLast  = 1'b0;
    w_selData  = '0;
    w_selStrb  = '0;
    w_selKeep  = '0;
    w_selDest  = '0;
    w_selUser  = '0;
    w_selId    = '0;
    for (int i = 0; i < RX_COUNT; i++) begin
      if (GRANT_WIDTH'(i) == r_grant) begin
        w_selValid = rx.tvalid[i];
        w_selLast  = rx.tlast[i];
        w_selData  = rx.tdata[i*DATA_W +: DATA_W];
        w_selStrb  = rx.tstrb[i*TDATA_BYTES +: TDATA_BYTES];
        w_selKeep  = rx.tkeep[i*TDATA_BYTES +: TDATA_BYTES];
        w_selDest  = rx.tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
        w_selUser  = rx.tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
        w_selId    = rx.tid[i*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  // Without tlast framing every accepted beat closes its own packet.
  assign w_beatLast = (USE_TLAST != 0) ? w_selLast : 1'b1;
  assign w_outReady = !r_txValid || tx.tready[0];
  assign w_ptrNext  = (r_grant == GRANT_WIDTH'(RX_COUNT - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_stateNext = r_state;
    w_rxReady   = '0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_stateNext = LOCKED;
      end
      LOCKED: begin
        for (int i = 0; i < RX_COUNT; i++) begin
          if (GRANT_WIDTH'(i) == r_grant) w_rxReady[i] = w_outReady;
        end
        w_xfer = w_selValid && w_outReady;
        if (w_xfer && w_beatLast) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_grantValid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state == IDLE) && w_any) begin
        r_grant      <= w_winner;
        r_grantValid <= 1'b1;
      end
      if (w_xfer && w_beatLast) begin
        r_ptr        <= w_ptrNext;
        r_grantValid <= 1'b0;
      end
    end
  end

  // Output stage: payload only moves when the slot is free or being drained, so it holds under stall.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_txValid <= 1'b0;
      r_txLast  <= 1'b0;
      r_txData  <= '0;
      r_txStrb  <= '0;
      r_txKeep  <= '0;
      r_txDest  <= '0;
      r_txUser  <= '0;
      r_txId    <= '0;
    end else if (w_outReady) begin
      r_txValid <= w_xfer;
      if (w_xfer) begin
        r_txLast <= w_beatLast;
        r_txData <= w_selData;
        r_txStrb <= w_selStrb;
        r_txKeep <= w_selKeep;
        r_txDest <= w_selDest;
        r_txUser <= w_selUser;
        r_txId   <= w_selId;
      end
    end
  end

  assign rx.tready   = w_rxReady;
  assign tx.tvalid   = r_txValid;
  assign tx.tlast    = r_txLast;
  assign tx.tdata    = r_txData;
  assign tx.tstrb    = r_txStrb;
  assign tx.tkeep    = r_txKeep;
  assign tx.tdest    = r_txDest;
  assign tx.tuser    = r_txUser;
  assign tx.tid      = r_txId;
  assign grant_valid = r_grantValid;
  assign grant       = r_grant;

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Directed bench for the packet arbiter with four sources: reset, contention order, wrap, stall, owner gap, reset abort.
module tb_logic_axi4_stream_packet_arbiter;

  logic       aclk = 1'b0;
  logic       areset_n;
  logic       grant_valid;
  logic [1:0] grant;

  always #5 aclk = ~aclk;

  logic_axi4_stream_packet_arbiter_if #(.N(4), .TDATA_BYTES(4)) rxIf ();
  logic_axi4_stream_packet_arbiter_if #(.N(1), .TDATA_BYTES(4)) txIf ();

  logic_axi4_stream_packet_arbiter #(
    .RX_COUNT    (4),
    .TDATA_BYTES (4),
    .TDEST_WIDTH (1),
    .TUSER_WIDTH (1),
    .TID_WIDTH   (1),
    .USE_TLAST   (1)
  ) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .rx          (rxIf),
    .tx          (txIf),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  int nAsserts = 0;
  int nFail    = 0;
  int cyc      = 0;

  int srcLen[4];
  int srcPktsLeft[4];
  int srcBeat[4];
  int srcPkt[4];
  bit srcGap[4];

  logic [43:0] obsQ[$];
  logic [43:0] expQ[$];
  int          obsCyc[$];

  // Beat word layout: {last, dest, user, id, keep, strb, data}; data = {src, pkt, beat}.
  function automatic logic [43:0] expBeat(input int src, input int pkt, input int beat, input bit last);
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [31:0] data;
    keep = 4'hF >> src;
    strb = 4'(1 << src);
    data = {8'(src), 8'(pkt), 16'(beat)};
    return {last, src[0], pkt[0], src[1], keep, strb, data};
  endfunction

  function automatic logic [43:0] txWord();
    return {txIf.tlast[0], txIf.tdest, txIf.tuser, txIf.tid, txIf.tkeep, txIf.tstrb, txIf.tdata};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      rxIf.tvalid[i]          = (srcPktsLeft[i] > 0) && !srcGap[i];
      rxIf.tlast[i]           = (srcBeat[i] == srcLen[i] - 1);
      rxIf.tdata[i*32 +: 32]  = {8'(i), 8'(srcPkt[i]), 16'(srcBeat[i])};
      rxIf.tkeep[i*4 +: 4]    = 4'hF >> i;
      rxIf.tstrb[i*4 +: 4]    = 4'(1 << i);
      rxIf.tdest[i]           = 1'(i);
      rxIf.tuser[i]           = 1'(srcPkt[i]);
      rxIf.tid[i]             = 1'(i >> 1);
    end
  endtask

  task automatic startPackets(input int src, input int count, input int len);
    srcPktsLeft[src] = count;
    srcLen[src]      = len;
    srcBeat[src]     = 0;
    applyStimulus();
  endtask

  task automatic expectPacket(input int src, input int pkt, input int len);
    for (int b = 0; b < len; b++) expQ.push_back(expBeat(src, pkt, b, b == len - 1));
  endtask

  // One clock: sample handshakes at the falling edge, then advance the source models after the rising edge.
  task automatic stepCycle();
    bit fire[4];
    @(negedge aclk);
    for (int i = 0; i < 4; i++) fire[i] = rxIf.tvalid[i] && rxIf.tready[i];
    if (txIf.tvalid[0] && txIf.tready[0]) begin
      obsQ.push_back(txWord());
      obsCyc.push_back(cyc);
    end
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        srcBeat[i]++;
        if (srcBeat[i] == srcLen[i]) begin
          srcBeat[i] = 0;
          srcPkt[i]++;
          srcPktsLeft[i]--;
        end
      end
    end
    applyStimulus();
  endtask

  task automatic checkObs(input string tag);
    checkOutput($sformatf("%s_count", tag), 64'(obsQ.size()), 64'(expQ.size()));
    for (int j = 0; j < expQ.size(); j++) begin
      if (j < obsQ.size()) checkOutput($sformatf("%s_beat%0d", tag, j), 64'(obsQ[j]), 64'(expQ[j]));
    end
    obsQ.delete();
    expQ.delete();
    obsCyc.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      srcLen[i] = 0; srcPktsLeft[i] = 0; srcBeat[i] = 0; srcPkt[i] = 0; srcGap[i] = 1'b0;
    end
    areset_n     = 1'b0;
    txIf.tready  = 1'b1;
    applyStimulus();

    // Reset held with every source valid; contention packets queued for after release.
    startPackets(0, 2, 3);
    startPackets(1, 1, 3);
    startPackets(2, 1, 3);
    startPackets(3, 1, 3);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput($sformatf("rst%0d_tx_tvalid", k), 64'(txIf.tvalid), 64'd0);
      checkOutput($sformatf("rst%0d_rx_tready", k), 64'(rxIf.tready), 64'd0);
      checkOutput($sformatf("rst%0d_grant_valid", k), 64'(grant_valid), 64'd0);
    end
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_tx_payload", 64'(txWord()), 64'd0);

    areset_n = 1'b1;
    for (int k = 0; k < 24; k++) stepCycle();
    for (int j = 0; j < obsCyc.size(); j++)
      checkOutput($sformatf("contend_cycle%0d", j), 64'(obsCyc[j] - obsCyc[0]), 64'(4 * (j / 3) + j % 3));
    expectPacket(0, 0, 3);
    expectPacket(1, 0, 3);
    expectPacket(2, 0, 3);
    expectPacket(3, 0, 3);
    expectPacket(0, 1, 3);
    checkObs("contend");

    // Pointer moves to 3 after source 2, so 3 must beat 0.
    startPackets(2, 1, 2);
    for (int k = 0; k < 6; k++) stepCycle();
    expectPacket(2, 1, 2);
    checkObs("wrap_src2");
    startPackets(0, 1, 2);
    startPackets(3, 1, 2);
    stepCycle();
    checkOutput("wrap_grant_valid", 64'(grant_valid), 64'd1);
    checkOutput("wrap_grant", 64'(grant), 64'd3);
    for (int k = 0; k < 10; k++) stepCycle();
    expectPacket(3, 1, 2);
    expectPacket(0, 2, 2);
    checkObs("wrap");

    // Backpressure: tready 1,0,0,1 while source 1 streams four beats.
    startPackets(1, 1, 4);
    stepCycle();
    stepCycle();
    stepCycle();
    txIf.tready = 1'b0;
    #1;
    checkOutput("bp_rx_tready_stall", 64'(rxIf.tready), 64'd0);
    checkOutput("bp_hold0", 64'(txWord()), 64'(expBeat(1, 1, 1, 1'b0)));
    stepCycle();
    checkOutput("bp_tvalid1", 64'(txIf.tvalid), 64'd1);
    checkOutput("bp_hold1", 64'(txWord()), 64'(expBeat(1, 1, 1, 1'b0)));
    stepCycle();
    checkOutput("bp_tvalid2", 64'(txIf.tvalid), 64'd1);
    checkOutput("bp_hold2", 64'(txWord()), 64'(expBeat(1, 1, 1, 1'b0)));
    txIf.tready = 1'b1;
    for (int k = 0; k < 6; k++) stepCycle();
    expectPacket(1, 1, 4);
    checkObs("bp");

    // Owner gap: source 1 idles five cycles mid-packet while source 0 waits.
    startPackets(1, 1, 4);
    stepCycle();
    checkOutput("gap_grant_start", 64'(grant), 64'd1);
    stepCycle();
    stepCycle();
    srcGap[1] = 1'b1;
    startPackets(0, 1, 2);
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput($sformatf("gap%0d_grant", k), 64'(grant), 64'd1);
      checkOutput($sformatf("gap%0d_grant_valid", k), 64'(grant_valid), 64'd1);
      checkOutput($sformatf("gap%0d_rx0_tready", k), 64'(rxIf.tready[0]), 64'd0);
    end
    srcGap[1] = 1'b0;
    applyStimulus();
    for (int k = 0; k < 10; k++) stepCycle();
    expectPacket(1, 2, 4);
    expectPacket(0, 3, 2);
    checkObs("gap");

    // Reset after two of four beats from source 3; pointer must restart at 0.
    startPackets(3, 1, 4);
    stepCycle();
    checkOutput("abort_grant_start", 64'(grant), 64'd3);
    stepCycle();
    stepCycle();
    areset_n = 1'b0;
    stepCycle();
    checkOutput("abort_tx_tvalid", 64'(txIf.tvalid), 64'd0);
    checkOutput("abort_grant_valid", 64'(grant_valid), 64'd0);
    checkOutput("abort_rx_tready", 64'(rxIf.tready), 64'd0);
    checkOutput("abort_tx_payload", 64'(txWord()), 64'd0);
    obsQ.delete();
    obsCyc.delete();
    srcBeat[3]     = 0;
    srcPktsLeft[3] = 1;
    startPackets(0, 1, 2);
    areset_n = 1'b1;
    stepCycle();
    checkOutput("abort_regrant_valid", 64'(grant_valid), 64'd1);
    checkOutput("abort_regrant", 64'(grant), 64'd0);
    for (int k = 0; k < 12; k++) stepCycle();
    expectPacket(0, 4, 2);
    expectPacket(3, 2, 4);
    checkObs("abort");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
